// File: rtl/lock_pkg.sv
// Shared lock-datapath definitions: code packing, digit geometry and the
// attempt-checker state encoding.
package lock_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DIGIT_CNT = 8;

  // Element [DIGIT_CNT-1] is digit1 (bits [31:28]); element [0] is digit8.
  typedef logic [DIGIT_CNT-1:0][DIGIT_W-1:0] code_t;

  typedef enum logic [1:0] {
    CHK_IDLE    = 2'd0,
    CHK_COMPARE = 2'd1,
    CHK_RESULT  = 2'd2,
    CHK_LOCKOUT = 2'd3
  } chk_state_t;

  // idx 0 selects digit1, idx 7 selects digit8.
  function automatic logic [DIGIT_W-1:0] get_digit(input code_t c, input logic [2:0] idx);
    return c[3'(DIGIT_CNT - 1) - idx];
  endfunction

endpackage

// File: rtl/attempt_checker_if.sv
// Request/result bundle between the lock controller (master) and the
// attempt checker (slave).
interface attempt_checker_if;
  import lock_pkg::*;

  logic       check_req;
  logic       relock;
  code_t      entered;
  code_t      password;
  logic       busy;
  logic       match_pulse;
  logic       fail_pulse;
  logic       unlocked;
  logic       locked_out;
  logic [2:0] fails;
  logic [7:0] lockout_left;

  modport master (
    output check_req, relock, entered, password,
    input  busy, match_pulse, fail_pulse, unlocked, locked_out, fails, lockout_left
  );

  modport slave (
    input  check_req, relock, entered, password,
    output busy, match_pulse, fail_pulse, unlocked, locked_out, fails, lockout_left
  );
endinterface

// File: rtl/sec_prescaler.sv
// Counts CLK_HZ enabled cycles and flags the last one of each period with
// a one-cycle sec_tick; i_clear restarts the period.
module sec_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_sec_tick
);

  localparam int              CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_count;

  assign o_sec_tick = i_en && (r_count == CNT_MAX);

  // NOTE: clocked state is always assigned with <= so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == CNT_MAX) ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/attempt_checker.sv
// Constant-time code comparison with failure counting; the timed lockout is
// built only when ATTEMPT_CHECKER_LOCKOUT_EN is defined.
module attempt_checker
  import lock_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int MAX_FAILS   = 3,
  parameter int LOCKOUT_SEC = 30
) (
  input logic              clk,
  input logic              rst_n,
  attempt_checker_if.slave bus
);

  localparam logic [1:0] S_IDLE    = CHK_IDLE;
  localparam logic [1:0] S_COMPARE = CHK_COMPARE;
  localparam logic [1:0] S_RESULT  = CHK_RESULT;
  localparam logic [1:0] S_LOCKOUT = CHK_LOCKOUT;

  logic [1:0] r_state, w_next_state;
  logic [2:0] r_idx;
  logic       r_mismatch;
  code_t      r_entered, r_password;
  logic       r_busy, r_match, r_fail, r_unlocked;
  logic [2:0] r_fails, w_fails_inc;
  logic       w_accept, w_digit_diff, w_result_match, w_result_fail;
  logic       w_lock_enter, w_lock_done;

  assign w_accept       = (r_state == S_IDLE) && bus.check_req;
  assign w_result_match = (r_state == S_RESULT) && !r_mismatch;
  assign w_result_fail  = (r_state == S_RESULT) && r_mismatch;
  assign w_fails_inc    = (r_fails == 3'd7) ? 3'd7 : r_fails + 3'd1;
  assign w_digit_diff   = get_digit(r_entered, r_idx) != get_digit(r_password, r_idx);

`ifdef ATTEMPT_CHECKER_LOCKOUT_EN
  logic       w_sec_tick, r_locked_out;
  logic [7:0] r_lockout_left;

  assign w_lock_enter = w_result_fail && (w_fails_inc >= 3'(MAX_FAILS));
  assign w_lock_done  = (r_state == S_LOCKOUT) && w_sec_tick && (r_lockout_left <= 8'd1);

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (r_state != S_LOCKOUT),
    .i_en       (r_state == S_LOCKOUT),
    .o_sec_tick (w_sec_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lockout_left <= '0;
      r_locked_out   <= 1'b0;
    end else begin
      r_locked_out <= (r_state == S_LOCKOUT);
      if (w_lock_enter) begin
        r_lockout_left <= 8'(LOCKOUT_SEC);
      end else if ((r_state == S_LOCKOUT) && w_sec_tick && (r_lockout_left != '0)) begin
        r_lockout_left <= r_lockout_left - 8'd1;
      end
    end
  end

  assign bus.locked_out   = r_locked_out;
  assign bus.lockout_left = r_lockout_left;
`else
  assign w_lock_enter     = 1'b0;
  assign w_lock_done      = 1'b0;
  assign bus.locked_out   = 1'b0;
  assign bus.lockout_left = '0;
`endif

  always_comb begin
    // NOTE: the default assignment up front keeps every path driven, so no
    // latch is inferred for w_next_state.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (bus.check_req) w_next_state = S_COMPARE;
      S_COMPARE: if (r_idx == 3'd7) w_next_state = S_RESULT;
      S_RESULT:  w_next_state = w_lock_enter ? S_LOCKOUT : S_IDLE;
      S_LOCKOUT: if (w_lock_done) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_mismatch <= 1'b0;
      r_entered  <= '0;
      r_password <= '0;
      r_busy     <= 1'b0;
      r_match    <= 1'b0;
      r_fail     <= 1'b0;
      r_unlocked <= 1'b0;
      r_fails    <= '0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (r_state != S_IDLE);
      r_match <= w_result_match;
      r_fail  <= w_result_fail;

      // Every digit is visited regardless of earlier differences, so the
      // result latency never leaks where the first wrong digit was.
      if (w_accept) begin
        r_entered  <= bus.entered;
        r_password <= bus.password;
        r_mismatch <= 1'b0;
        r_idx      <= '0;
      end else if (r_state == S_COMPARE) begin
        r_mismatch <= r_mismatch | w_digit_diff;
        r_idx      <= r_idx + 3'd1;
      end

      // A match outranks a coincident relock.
      if (w_result_match) begin
        r_unlocked <= 1'b1;
      end else if (bus.relock) begin
        r_unlocked <= 1'b0;
      end

      if (w_result_match || w_lock_done) begin
        r_fails <= '0;
      end else if (w_result_fail) begin
        r_fails <= w_fails_inc;
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.match_pulse = r_match;
  assign bus.fail_pulse  = r_fail;
  assign bus.unlocked    = r_unlocked;
  assign bus.fails       = r_fails;

endmodule
